// File: rtl/riscv_pkg.sv
// Shared constants and types for the RV32I register file and its dump port.
package riscv_pkg;
  localparam int XLEN      = 32;
  localparam int NREGS     = 32;
  localparam int REG_IDX_W = $clog2(NREGS);
  localparam int RS1_LSB   = 15;
  localparam int RS2_LSB   = 20;
  localparam int RD_LSB    = 7;

  typedef enum logic [1:0] {
    DUMP_IDLE = 2'd0,
    DUMP_SEND = 2'd1,
    DUMP_DONE = 2'd2
  } dump_state_t;
endpackage

// File: rtl/reg_dump_fsm.sv
// Serial valid/ready streamer of the architectural registers, one register per beat.
// The parent supplies the (write-first) value of rd_idx; each beat is a snapshot
// taken when it is loaded, so writes to the presented index do not disturb it.
module reg_dump_fsm
  import riscv_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 dump_req,
  input  logic                 dump_ready,
  input  logic [XLEN-1:0]      rd_data,
  output logic [REG_IDX_W-1:0] rd_idx,
  output logic                 dump_valid,
  output logic [REG_IDX_W-1:0] dump_idx,
  output logic [XLEN-1:0]      dump_data,
  output logic                 dump_done
);
  localparam logic [REG_IDX_W-1:0] LAST_IDX = REG_IDX_W'(NREGS - 1);

  dump_state_t            state_reg, state_next;
  logic [REG_IDX_W-1:0]   idx_reg, idx_next;
  logic [XLEN-1:0]        data_reg, data_next;

  // State, beat index and beat snapshot registers; low reset aborts any dump.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= DUMP_IDLE;
      idx_reg   <= '0;
      data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      data_reg  <= data_next;
    end
  end

  // Next-state, next-beat load and handshake outputs.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    data_next  = data_reg;
    rd_idx     = idx_reg + REG_IDX_W'(1);
    dump_valid = 1'b0;
    dump_done  = 1'b0;
    case (state_reg)
      DUMP_IDLE: begin
        rd_idx = '0;
        if (dump_req) begin
          state_next = DUMP_SEND;
          idx_next   = '0;
          data_next  = rd_data;
        end
      end
      DUMP_SEND: begin
        dump_valid = 1'b1;
        if (dump_ready) begin
          if (idx_reg == LAST_IDX) begin
            state_next = DUMP_DONE;
          end else begin
            idx_next  = idx_reg + REG_IDX_W'(1);
            data_next = rd_data;
          end
        end
      end
      DUMP_DONE: begin
        dump_done  = 1'b1;
        state_next = DUMP_IDLE;
      end
      default: state_next = DUMP_IDLE;
    endcase
  end

  assign dump_idx  = idx_reg;
  assign dump_data = data_reg;
endmodule

// File: rtl/reg_file.sv
// 32x32 RV32I integer register file: two bypassed combinational read ports,
// one write-back port, x0 hard-wired to zero, plus a serial register dump port.
module reg_file
  import riscv_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          idata,
  input  logic                 we,
  input  logic [XLEN-1:0]      wdata,
  output logic [XLEN-1:0]      rv1,
  output logic [XLEN-1:0]      rv2,
  output logic [XLEN-1:0]      x31,
  input  logic                 dump_req,
  output logic                 dump_valid,
  input  logic                 dump_ready,
  output logic [REG_IDX_W-1:0] dump_idx,
  output logic [XLEN-1:0]      dump_data,
  output logic                 dump_done
);
  logic [XLEN-1:0]      regs [NREGS];
  logic [REG_IDX_W-1:0] rs1, rs2, rd;
  logic [REG_IDX_W-1:0] dump_rd_idx;
  logic [XLEN-1:0]      dump_rd_data;
  logic                 wr_en;
  logic                 unused_idata_bits;

  assign rs1 = idata[RS1_LSB +: REG_IDX_W];
  assign rs2 = idata[RS2_LSB +: REG_IDX_W];
  assign rd  = idata[RD_LSB  +: REG_IDX_W];
  assign unused_idata_bits = ^{idata[31:25], idata[14:12], idata[6:0]};

  // x0 is never written, so it stays at its reset value of zero.
  assign wr_en = we && (rd != '0);

  // Register storage: cleared by reset, one write-back port.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[rd] <= wdata;
    end
  end

  // Same-cycle write-back is forwarded to the operand ports and the dump loader.
  assign rv1          = (wr_en && rd == rs1)         ? wdata : regs[rs1];
  assign rv2          = (wr_en && rd == rs2)         ? wdata : regs[rs2];
  assign dump_rd_data = (wr_en && rd == dump_rd_idx) ? wdata : regs[dump_rd_idx];
  assign x31          = regs[NREGS-1];

  reg_dump_fsm u_dump (
    .clk        (clk),
    .reset      (reset),
    .dump_req   (dump_req),
    .dump_ready (dump_ready),
    .rd_data    (dump_rd_data),
    .rd_idx     (dump_rd_idx),
    .dump_valid (dump_valid),
    .dump_idx   (dump_idx),
    .dump_data  (dump_data),
    .dump_done  (dump_done)
  );
endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file with a behavioural model checked every cycle.
module tb_reg_file;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] idata;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rv1, rv2, x31;
  logic        dump_req, dump_valid, dump_ready, dump_done;
  logic [4:0]  dump_idx;
  logic [31:0] dump_data;

  int checks = 0;
  int failures = 0;

  reg_file dut (
    .clk(clk), .reset(reset), .idata(idata), .we(we), .wdata(wdata),
    .rv1(rv1), .rv2(rv2), .x31(x31),
    .dump_req(dump_req), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_idx(dump_idx), .dump_data(dump_data), .dump_done(dump_done)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [31:0] m_regs [32];
  bit          m_sending = 0;   // a dump beat is being presented
  bit          m_done    = 0;   // completion pulse this cycle
  int          m_idx     = 0;
  logic [31:0] m_data    = '0;
  bit          m_live    = 0;   // model has seen a reset

  function automatic logic [4:0] f_rs1(input logic [31:0] i); return i[19:15]; endfunction
  function automatic logic [4:0] f_rs2(input logic [31:0] i); return i[24:20]; endfunction
  function automatic logic [4:0] f_rd (input logic [31:0] i); return i[11:7];  endfunction

  // Value of register k as seen this cycle, with the pending write taking effect.
  function automatic logic [31:0] read_now(input int k);
    if (k == 0) return 32'd0;
    if (we && int'(f_rd(idata)) == k) return wdata;
    return m_regs[k];
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < 32; k++) m_regs[k] <= '0;
      m_sending <= 0; m_done <= 0; m_idx <= 0; m_data <= '0; m_live <= 1;
    end else begin
      if (we && f_rd(idata) != 0) m_regs[f_rd(idata)] <= wdata;
      m_done <= 0;
      if (m_sending) begin
        if (dump_ready) begin
          if (m_idx == 31) begin
            m_sending <= 0; m_done <= 1;
          end else begin
            m_idx <= m_idx + 1; m_data <= read_now(m_idx + 1);
          end
        end
      end else if (!m_done && dump_req) begin
        m_sending <= 1; m_idx <= 0; m_data <= 32'd0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h t=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_live) begin
      chk("m_rv1", rv1, read_now(int'(f_rs1(idata))));
      chk("m_rv2", rv2, read_now(int'(f_rs2(idata))));
      chk("m_x31", x31, m_regs[31]);
      chk("m_valid", {31'd0, dump_valid}, {31'd0, m_sending});
      chk("m_done", {31'd0, dump_done}, {31'd0, m_done});
      if (m_sending) begin
        chk("m_idx", {27'd0, dump_idx}, m_idx);
        chk("m_data", dump_data, m_data);
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [31:0] instr(input int r1, input int r2, input int d);
    logic [4:0] a, b, c;
    a = 5'(r1); b = 5'(r2); c = 5'(d);
    return {7'd0, b, a, 3'd0, c, 7'h33};
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Advance until a beat with index target is presented, bounded.
  task automatic wait_idx(input int target, input string name);
    int n = 0;
    while (!(dump_valid && int'(dump_idx) == target) && n < 60) begin
      step(); n++;
    end
    chk(name, {31'd0, dump_valid && int'(dump_idx) == target}, 32'd1);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!dump_done && n < 60) begin
      step(); n++;
    end
    chk(name, {31'd0, dump_done}, 32'd1);
  endtask

  int beats;
  bit order_ok;

  initial begin
    reset = 1'b0; idata = '0; we = 1'b0; wdata = '0; dump_req = 1'b0; dump_ready = 1'b0;
    #1;
    // 1: reset blocks writes
    we = 1'b1; idata = instr(0, 0, 5); wdata = 32'h0000DEAD;
    step(); step();
    we = 1'b0; idata = instr(5, 31, 0); #1;
    chk("rst_rv1_x5", rv1, 32'd0);
    chk("rst_x31", x31, 32'd0);
    chk("rst_valid", {31'd0, dump_valid}, 32'd0);
    chk("rst_done", {31'd0, dump_done}, 32'd0);
    $display("txn reset: x5=%0d valid=%0b", rv1, dump_valid);
    reset = 1'b1;
    step();

    // 2: write then read, x0 discard
    we = 1'b1; idata = instr(0, 0, 3); wdata = 32'd1073741824;
    step();
    we = 1'b0; idata = instr(3, 0, 0); #1;
    chk("wr_x3", rv1, 32'd1073741824);
    $display("txn write x3: rv1=%0d", rv1);
    we = 1'b1; idata = instr(0, 0, 0); wdata = 32'd7;
    step();
    we = 1'b0; idata = instr(0, 0, 0); #1;
    chk("wr_x0", rv1, 32'd0);
    $display("txn write x0: rv1=%0d", rv1);

    // 3: bypass
    we = 1'b1; idata = instr(9, 9, 9); wdata = 32'hFFFFFFFB; #1;
    chk("byp_rv1", rv1, 32'hFFFFFFFB);
    chk("byp_rv2", rv2, 32'hFFFFFFFB);
    step();
    we = 1'b0; idata = instr(9, 0, 0); #1;
    chk("byp_stored", rv1, 32'hFFFFFFFB);
    $display("txn bypass x9: rv1=%0d", $signed(rv1));

    // 4: full dump of xN = 3N
    for (int n = 1; n < 32; n++) begin
      we = 1'b1; idata = instr(0, 0, n); wdata = 32'(3 * n);
      step();
    end
    we = 1'b0; idata = '0;
    chk("pre_x31", x31, 32'd93);
    dump_ready = 1'b1; dump_req = 1'b1;
    step();
    dump_req = 1'b0;
    beats = 0; order_ok = 1;
    for (int n = 0; n < 40 && beats < 32; n++) begin
      if (dump_valid) begin
        if (int'(dump_idx) != beats || dump_data != 32'(3 * beats)) order_ok = 0;
        $display("txn beat idx=%0d data=%0d", dump_idx, dump_data);
        beats++;
      end
      step();
    end
    chk("dump_beats", beats, 32'd32);
    chk("dump_order", {31'd0, order_ok}, 32'd1);
    chk("dump_done_pulse", {31'd0, dump_done}, 32'd1);
    step();
    chk("dump_done_clear", {31'd0, dump_done}, 32'd0);
    chk("dump_idle", {31'd0, dump_valid}, 32'd0);

    // 5: backpressure at idx 7 with concurrent write to x7
    dump_req = 1'b1;
    step();
    dump_req = 1'b0;
    wait_idx(7, "bp_reach7");
    dump_ready = 1'b0; we = 1'b1; idata = instr(0, 0, 7); wdata = 32'h55;
    for (int n = 0; n < 4; n++) begin
      step();
      chk("bp_idx", {27'd0, dump_idx}, 32'd7);
      chk("bp_data", dump_data, 32'd21);
    end
    $display("txn backpressure: idx=%0d data=%0d", dump_idx, dump_data);
    we = 1'b0; idata = '0; dump_ready = 1'b1;
    step();
    chk("bp_next_idx", {27'd0, dump_idx}, 32'd8);
    chk("bp_next_data", dump_data, 32'd24);
    wait_done("bp_done");
    step();

    // 6: reset mid-dump
    dump_req = 1'b1;
    step();
    dump_req = 1'b0;
    wait_idx(12, "mid_reach12");
    reset = 1'b0;
    step();
    reset = 1'b1; idata = instr(3, 31, 0); #1;
    chk("mid_valid", {31'd0, dump_valid}, 32'd0);
    chk("mid_done", {31'd0, dump_done}, 32'd0);
    chk("mid_x3", rv1, 32'd0);
    chk("mid_x31", x31, 32'd0);
    step(); step();
    chk("mid_no_done", {31'd0, dump_done}, 32'd0);
    dump_req = 1'b1;
    step();
    dump_req = 1'b0;
    chk("restart_valid", {31'd0, dump_valid}, 32'd1);
    chk("restart_idx", {27'd0, dump_idx}, 32'd0);
    chk("restart_data", dump_data, 32'd0);
    $display("txn restart: valid=%0b idx=%0d", dump_valid, dump_idx);
    wait_done("restart_done");
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
